// File: rtl/reg_bank_ctrl.sv
// Sequencer for a bank of two-read-port registers. It is the bank's only driver:
// it owns the D bus and the one-hot write/read enables, and returns read results
// over a valid/ready response port.
// Optional build macro: REG_BANK_CTRL_VERIFY_EN adds a read-back check after every write.
module reg_bank_ctrl #(
  parameter int NREG = 8,
  parameter int AW   = 3,
  parameter int DW   = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [AW-1:0]   cmd_addr_a,
  input  logic [AW-1:0]   cmd_addr_b,
  input  logic [DW-1:0]   cmd_data,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_a,
  output logic [DW-1:0]   rsp_b,
  output logic            rsp_err,
  output logic [DW-1:0]   bank_d,
  output logic [NREG-1:0] bank_wr_en,
  output logic [NREG-1:0] bank_rd_a,
  output logic [NREG-1:0] bank_rd_b,
  input  logic [DW-1:0]   bus_a,
  input  logic [DW-1:0]   bus_b
);

  // state    | meaning
  // IDLE     | ready for a command
  // WR       | D bus and one write enable driven; register loads at the next edge
  // RD_EN    | read enables driven, bus settling
  // RD_CAP   | read enables held, buses captured into rsp_a/rsp_b
  // RSP      | response held until the consumer takes it
  // VF_EN    | (verify build) bus A read-back of the address just written
  // VF_CAP   | (verify build) read-back compared against the written data
`ifdef REG_BANK_CTRL_VERIFY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_RD_EN, S_RD_CAP, S_RSP, S_VF_EN, S_VF_CAP
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_RD_EN, S_RD_CAP, S_RSP
  } state_t;
`endif

  localparam logic [1:0] OP_WRITE = 2'b00;

  state_t          state_q, state_d;
  logic [1:0]      op_q;
  logic [AW-1:0]   addr_a_q, addr_b_q;
  logic [DW-1:0]   data_q;
  logic [DW-1:0]   rsp_a_q, rsp_b_q;
  logic [NREG-1:0] dec_a, dec_b;
  logic            accept;

  // Out-of-range addresses shift the single bit off the top and decode to all zeros.
  function automatic logic [NREG-1:0] onehot(input logic [AW-1:0] addr);
    onehot = NREG'(1) << addr;
  endfunction

  assign dec_a  = onehot(addr_a_q);
  assign dec_b  = onehot(addr_b_q);
  assign accept = cmd_valid & cmd_ready;
  assign rsp_a  = rsp_a_q;
  assign rsp_b  = rsp_b_q;

  always_comb begin
    state_d    = state_q;
    cmd_ready  = 1'b0;
    rsp_valid  = 1'b0;
    bank_d     = '0;
    bank_wr_en = '0;
    bank_rd_a  = '0;
    bank_rd_b  = '0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = rst_n;
        if (cmd_valid && rst_n) begin
          state_d = (cmd_op == OP_WRITE) ? S_WR : S_RD_EN;
        end
      end
      S_WR: begin
        bank_d     = data_q;
        bank_wr_en = dec_a;
`ifdef REG_BANK_CTRL_VERIFY_EN
        state_d    = S_VF_EN;
`else
        state_d    = S_IDLE;
`endif
      end
      S_RD_EN: begin
        bank_rd_a = op_q[0] ? dec_a : '0;
        bank_rd_b = op_q[1] ? dec_b : '0;
        state_d   = S_RD_CAP;
      end
      S_RD_CAP: begin
        bank_rd_a = op_q[0] ? dec_a : '0;
        bank_rd_b = op_q[1] ? dec_b : '0;
        state_d   = S_RSP;
      end
      S_RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
`ifdef REG_BANK_CTRL_VERIFY_EN
      S_VF_EN: begin
        bank_rd_a = dec_a;
        state_d   = S_VF_CAP;
      end
      S_VF_CAP: begin
        bank_rd_a = dec_a;
        state_d   = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      data_q   <= '0;
      rsp_a_q  <= '0;
      rsp_b_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q     <= cmd_op;
        addr_a_q <= cmd_addr_a;
        addr_b_q <= cmd_addr_b;
        data_q   <= cmd_data;
      end
      // Unread ports and out-of-range addresses return zero, never bus garbage.
      if (state_q == S_RD_CAP) begin
        rsp_a_q <= (op_q[0] && (|dec_a)) ? bus_a : '0;
        rsp_b_q <= (op_q[1] && (|dec_b)) ? bus_b : '0;
      end
    end
  end

`ifdef REG_BANK_CTRL_VERIFY_EN
  logic rsp_err_q;

  // Sticky until reset; a write to a non-existent register has nothing to verify.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_err_q <= 1'b0;
    end else if ((state_q == S_VF_CAP) && (|dec_a) && (bus_a != data_q)) begin
      rsp_err_q <= 1'b1;
    end
  end

  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_reg_bank_ctrl.sv
// Self-checking bench for reg_bank_ctrl: directed scenarios plus random traffic,
// checked against a transaction-level memory model of the register bank.
module tb_reg_bank_ctrl;
  localparam int NREG = 8;
  localparam int AW   = 3;
  localparam int DW   = 32;
`ifdef REG_BANK_CTRL_VERIFY_EN
  localparam int WR_OCC = 4;
  localparam bit VERIFY = 1'b1;
`else
  localparam int WR_OCC = 2;
  localparam bit VERIFY = 1'b0;
`endif

  logic            clk;
  logic            rst_n;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [1:0]      cmd_op;
  logic [AW-1:0]   cmd_addr_a;
  logic [AW-1:0]   cmd_addr_b;
  logic [DW-1:0]   cmd_data;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [DW-1:0]   rsp_a;
  logic [DW-1:0]   rsp_b;
  logic            rsp_err;
  logic [DW-1:0]   bank_d;
  logic [NREG-1:0] bank_wr_en;
  logic [NREG-1:0] bank_rd_a;
  logic [NREG-1:0] bank_rd_b;
  logic [DW-1:0]   bus_a;
  logic [DW-1:0]   bus_b;

  reg_bank_ctrl #(.NREG(NREG), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr_a(cmd_addr_a), .cmd_addr_b(cmd_addr_b), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_a(rsp_a), .rsp_b(rsp_b), .rsp_err(rsp_err),
    .bank_d(bank_d), .bank_wr_en(bank_wr_en),
    .bank_rd_a(bank_rd_a), .bank_rd_b(bank_rd_b),
    .bus_a(bus_a), .bus_b(bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register bank stand-in; undriven buses float to a recognisable junk pattern.
  logic [DW-1:0] bank [NREG];
  bit            corrupt_a;

  initial for (int i = 0; i < NREG; i++) bank[i] = '0;

  always @(posedge clk) begin
    for (int i = 0; i < NREG; i++) if (bank_wr_en[i]) bank[i] <= bank_d;
  end

  always_comb begin
    bus_a = 32'hDEAD_BEEF;
    bus_b = 32'hBAD0_CAFE;
    for (int i = 0; i < NREG; i++) begin
      if (bank_rd_a[i]) bus_a = corrupt_a ? '0 : bank[i];
      if (bank_rd_b[i]) bus_b = bank[i];
    end
  end

  // Reference model: contents the bank should hold, and the expected error flag.
  logic [DW-1:0] ref_mem [NREG];
  bit            ref_err;
  int            errors, checks;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [NREG-1:0] exp_oh(input int a);
    return (a < NREG) ? NREG'(1 << a) : '0;
  endfunction

  function automatic logic [DW-1:0] exp_rd(input int a);
    return (a < NREG) ? ref_mem[a] : '0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!cmd_ready && n < 20) begin
      tick();
      n++;
    end
    if (!cmd_ready) check_val({tag, "_ready_timeout"}, 32'(cmd_ready), 32'd1);
  endtask

  task automatic do_write(input int a, input logic [DW-1:0] d);
    int n;
    wait_ready("wr");
    cmd_valid  = 1'b1;
    cmd_op     = 2'b00;
    cmd_addr_a = AW'(a);
    cmd_addr_b = AW'($urandom);
    cmd_data   = d;
    tick();
    cmd_valid = 1'b0;
    check_val("wr_en", 32'(bank_wr_en), 32'(exp_oh(a)));
    check_val("wr_d", bank_d, d);
    check_val("wr_no_rd", 32'({bank_rd_a, bank_rd_b}), 32'd0);
    check_val("wr_busy", 32'(cmd_ready), 32'd0);
    if (a < NREG) ref_mem[a] = d;
    if (VERIFY && corrupt_a && (a < NREG) && (d != '0)) ref_err = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!cmd_ready && n < 10);
    check_val("wr_occupancy", 32'(n), 32'(WR_OCC - 1));
    check_val("wr_en_dropped", 32'(bank_wr_en), 32'd0);
    check_val("rsp_err", 32'(rsp_err), 32'(ref_err));
  endtask

  task automatic do_read(input logic [1:0] op, input int a, input int b, input int hold);
    logic [NREG-1:0] ea, eb;
    logic [DW-1:0]   xa, xb;
    wait_ready("rd");
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_addr_a = AW'(a);
    cmd_addr_b = AW'(b);
    cmd_data   = $urandom;
    tick();
    cmd_valid = 1'b0;
    ea = op[0] ? exp_oh(a) : '0;
    eb = op[1] ? exp_oh(b) : '0;
    xa = op[0] ? exp_rd(a) : '0;
    xb = op[1] ? exp_rd(b) : '0;
    for (int p = 0; p < 2; p++) begin
      check_val("rd_en_a", 32'(bank_rd_a), 32'(ea));
      check_val("rd_en_b", 32'(bank_rd_b), 32'(eb));
      check_val("rd_no_wr", 32'(bank_wr_en), 32'd0);
      check_val("rd_early_valid", 32'(rsp_valid), 32'd0);
      tick();
    end
    check_val("rsp_valid", 32'(rsp_valid), 32'd1);
    check_val("rsp_a", rsp_a, xa);
    check_val("rsp_b", rsp_b, xb);
    check_val("rsp_en_off", 32'({bank_wr_en, bank_rd_a, bank_rd_b}), 32'd0);
    for (int h = 0; h < hold; h++) begin
      cmd_valid = 1'b1;
      cmd_op    = 2'($urandom);
      tick();
      check_val("hold_valid", 32'(rsp_valid), 32'd1);
      check_val("hold_rsp_a", rsp_a, xa);
      check_val("hold_rsp_b", rsp_b, xb);
      check_val("hold_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    check_val("rsp_taken", 32'(rsp_valid), 32'd0);
    check_val("ready_after_rsp", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    errors = 0;
    checks = 0;
    ref_err = 1'b0;
    corrupt_a = 1'b0;
    for (int i = 0; i < NREG; i++) ref_mem[i] = '0;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = 2'b00;
    cmd_addr_a = '0;
    cmd_addr_b = '0;
    cmd_data = '0;
    rsp_ready = 1'b0;

    // Reset held for two edges
    tick();
    tick();
    check_val("rst_en", 32'({bank_wr_en, bank_rd_a, bank_rd_b}), 32'd0);
    check_val("rst_d", bank_d, 32'd0);
    check_val("rst_valid", 32'(rsp_valid), 32'd0);
    check_val("rst_ready", 32'(cmd_ready), 32'd0);
    check_val("rst_rsp_a", rsp_a, 32'd0);
    check_val("rst_err", 32'(rsp_err), 32'd0);
    rst_n = 1'b1;
    tick();
    check_val("ready_after_rst", 32'(cmd_ready), 32'd1);

    // Write then read back the same address
    do_write(3, 32'hA5A5_A5A5);
    do_read(2'b01, 3, 0, 0);

    // Dual-port read of two distinct registers, then the same register on both ports
    do_write(1, 32'hFFFF_FFFF);
    do_write(2, 32'h0000_0000);
    do_read(2'b11, 1, 2, 0);
    do_read(2'b11, 1, 1, 0);
    do_read(2'b10, 5, 1, 0);

    // Consumer back-pressure with a competing command pending
    do_read(2'b11, 3, 1, 5);

    // Reset during the bus-settle cycle of a read
    wait_ready("rst_rd");
    cmd_valid  = 1'b1;
    cmd_op     = 2'b01;
    cmd_addr_a = AW'(3);
    tick();
    cmd_valid = 1'b0;
    check_val("abort_rd_en", 32'(bank_rd_a), 32'(exp_oh(3)));
    rst_n = 1'b0;
    tick();
    check_val("abort_en_off", 32'({bank_wr_en, bank_rd_a, bank_rd_b}), 32'd0);
    check_val("abort_no_valid", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    ref_err = 1'b0;
    tick();
    check_val("abort_no_valid2", 32'(rsp_valid), 32'd0);
    check_val("abort_ready", 32'(cmd_ready), 32'd1);
    do_read(2'b01, 3, 0, 0);

    // Random traffic
    for (int t = 0; t < 150; t++) begin
      logic [1:0] op;
      op = 2'($urandom_range(0, 3));
      if (op == 2'b00) do_write(int'($urandom_range(0, NREG - 1)), $urandom);
      else do_read(op, int'($urandom_range(0, NREG - 1)), int'($urandom_range(0, NREG - 1)),
                   int'($urandom_range(0, 3)));
    end

    // Read-back corruption on bus A during a write
    corrupt_a = 1'b1;
    do_write(5, 32'h1234_5678);
    corrupt_a = 1'b0;
    do_write(6, 32'h0F0F_0F0F);
    do_read(2'b11, 5, 6, 1);
    check_val("err_sticky", 32'(rsp_err), 32'(ref_err));

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    ref_err = 1'b0;
    tick();
    check_val("err_cleared", 32'(rsp_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
